// File: rtl/bcd_stopwatch_core_if.sv
// Button inputs and display-facing outputs of the BCD stopwatch core.
// master drives the buttons and observes the count; slave is the core itself.
interface bcd_stopwatch_core_if;
    logic        i_w_startStop;
    logic        i_w_clear;
    logic [15:0] o_r_bcd;
    logic        o_r_running;
    logic        o_r_wrap;

    modport master (
        output i_w_startStop,
        output i_w_clear,
        input  o_r_bcd,
        input  o_r_running,
        input  o_r_wrap
    );

    modport slave (
        input  i_w_startStop,
        input  i_w_clear,
        output o_r_bcd,
        output o_r_running,
        output o_r_wrap
    );
endinterface

// File: rtl/bcd_stopwatch_core.sv
// SS.cc stopwatch: synchronised/debounced buttons drive an IDLE/RUN/PAUSED FSM over a prescaled BCD count.
// Press reaches the FSM 2 sync + DEBOUNCE_CYCLES + 1 cycles after the raw edge; no backpressure, outputs registered.
module bcd_stopwatch_core #(
    parameter int TICK_DIV        = 1000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_reset,
    bcd_stopwatch_core_if.slave  sw
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    // Bit 0 is startStop, bit 1 is clear throughout the conditioning path.
    logic [1:0]         btn_raw;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         stable_q, stable_d, stable_dly_q;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         press;
    logic               ss_ev, clr_ev;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [15:0]        bcd_q, bcd_d, bcd_inc;
    logic               running_q;
    logic               wrap_q, wrap_d;
    logic               tick;

    assign btn_raw = {sw.i_w_clear, sw.i_w_startStop};

    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                deb_cnt_d[b] = '0;
            end else if (deb_cnt_q[b] == DEB_LAST) begin
                stable_d[b]  = sync2_q[b];
                deb_cnt_d[b] = '0;
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
            end
        end
    end

    // Rising edge of the accepted level only; releases never produce an event.
    assign press  = stable_q & ~stable_dly_q;
    assign ss_ev  = press[0];
    assign clr_ev = press[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ss_ev) state_d = ST_RUN;
            ST_RUN:    if (ss_ev) state_d = ST_PAUSED;
            ST_PAUSED: begin
                if (clr_ev)     state_d = ST_IDLE;
                else if (ss_ev) state_d = ST_RUN;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // PAUSED leaves the prescaler untouched so a resumed interval finishes where it left off.
    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        wrap_d  = 1'b0;
        if (state_d == ST_IDLE) begin
            presc_d = '0;
            bcd_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                presc_d = '0;
                bcd_d   = bcd_inc;
                wrap_d  = (bcd_q == 16'h9999);
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            deb_cnt_q    <= '0;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            bcd_q        <= '0;
            running_q    <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            bcd_q        <= bcd_d;
            running_q    <= (state_d == ST_RUN);
            wrap_q       <= wrap_d;
        end
    end

    assign sw.o_r_bcd     = bcd_q;
    assign sw.o_r_running = running_q;
    assign sw.o_r_wrap    = wrap_q;
endmodule

// File: doc/bcd_stopwatch_core.md
Name: bcd_stopwatch_core

Overview:
Four-digit BCD stopwatch engine, format SS.cc (tens-sec, units-sec, tenths, hundredths). It sits directly upstream of the four-digit multiplexed seven-segment driver and feeds it a 16-bit packed BCD value plus run status. Raw board pushbuttons are synchronised and debounced on-chip. The block provides start/stop and clear control over a prescaled centisecond counter.

Parameters:
TICK_DIV, 1000000, clock cycles per count increment (100 MHz -> 10 ms); legal range >= 2
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a button level change; legal range >= 2

Ports:
i_w_clk  input  1  system clock, all flops on rising edge
i_w_reset  input  1  asynchronous active-low reset; 0 resets all state immediately
i_w_startStop  input  1  raw pushbutton, active high, asynchronous to clock, bouncy
i_w_clear  input  1  raw pushbutton, active high, asynchronous to clock, bouncy
o_r_bcd  output  16  packed digits: [15:12] tens-sec, [11:8] units-sec, [7:4] tenths, [3:0] hundredths
o_r_running  output  1  high while state is RUN
o_r_wrap  output  1  single-cycle pulse when the count rolls 99.99 -> 00.00

Behaviour:
- Reset (i_w_reset=0, asynchronous): state IDLE; o_r_bcd=16'h0000; o_r_running=0; o_r_wrap=0. Prescaler, debounce counters, synchronisers and stable levels all cleared to 0.
- Input conditioning, per button independently:
  - 2-flop synchroniser.
  - Debounce counter resets to 0 whenever the synchronised level equals the current stable level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the level still differs, the stable level takes the new value and the counter returns to 0.
  - Press event is a 1-cycle pulse, asserted on the cycle after stable level goes 0->1.
  - Releases generate no event. A button held down generates exactly one event.
- State machine: IDLE, RUN, PAUSED. Transitions occur on the clock edge where the event pulse is high.
  - IDLE: startStop -> RUN. clear -> stay IDLE.
  - RUN: startStop -> PAUSED. clear is ignored.
  - PAUSED: startStop -> RUN. clear -> IDLE.
  - Simultaneous events: in RUN, startStop wins (-> PAUSED) and clear is dropped. In PAUSED, clear wins (-> IDLE) and startStop is dropped. In IDLE, startStop wins (-> RUN).
  - Entering IDLE zeroes o_r_bcd and the prescaler on that same edge.
- Prescaler: counts 0..TICK_DIV-1 only while in RUN.
  - On the edge where it equals TICK_DIV-1, it returns to 0 and the BCD count increments on that same edge.
  - In PAUSED the prescaler holds its value, so the partial interval is preserved across pause/resume.
  - On IDLE->RUN the prescaler starts from 0. The first increment appears TICK_DIV cycles after o_r_running rises.
- BCD increment: ripple-carry across digits, each digit in 0..9. Digit 0 wraps 9->0 and carries into digit 1, and so on up to digit 3.
  - At 9999 an increment yields 0000 and pulses o_r_wrap high for exactly that one cycle. State remains RUN.
  - Digit values 10..15 never appear on o_r_bcd.
- o_r_running is registered and equals (state==RUN).
- o_r_bcd changes only on an increment edge or on entry to IDLE. It is stable across PAUSED.
- Reset asserted mid-count or mid-debounce: immediate return to reset values. After reset release, a button still held needs a full debounce window before the press is accepted.

Test Plan:
(Bench parameters: TICK_DIV=4, DEBOUNCE_CYCLES=3.)
- Reset: assert i_w_reset=0 mid-RUN at count 0x0123 -> o_r_bcd=0x0000 and o_r_running=0 with no clock edge; state IDLE after release.
- Debounce: toggle i_w_startStop 1,0,1,0 on alternate cycles, then hold 1 for 10 cycles -> exactly one event, o_r_running=1; releasing generates no event.
- Counting: from IDLE, press start, run 40 cycles after o_r_running rises -> o_r_bcd=0x0010; sample at 36 cycles -> 0x0009.
- Pause/resume: pause 2 cycles into an interval, wait 50 cycles -> o_r_bcd unchanged; resume -> next increment 2 cycles after o_r_running rises.
- Wrap: preload the count to 0x9999 by running, then take one more tick -> o_r_bcd=0x0000, o_r_wrap high 1 cycle, o_r_running stays 1.
- Clear rules: clear in RUN -> ignored. Pause at 0x0042, then press clear and start simultaneously -> IDLE, o_r_bcd=0x0000, o_r_running=0.
